// File: rtl/reg_writeback_queue_pkg.sv
// Shared defaults and helpers for the register write-back queue.
package reg_writeback_queue_pkg;
  localparam int WB_DEPTH  = 4;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int WB_CNT_W  = 2;
  localparam int NUM_REGS  = 32;
  localparam logic [WB_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/reg_writeback_queue_fifo.sv
// 2-push/1-pop circular queue; slot A is written ahead of slot B.
// REG_WRITEBACK_BYPASS_EN adds an age-ordered view of the entries (oldest first).
module wb_fifo
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int W     = WB_ADDR_W + WB_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_a_i,
  input  logic [W-1:0]                din_a_i,
  input  logic                        push_b_i,
  input  logic [W-1:0]                din_b_i,
  input  logic                        pop_i,
  output logic [W-1:0]                head_o,
`ifdef REG_WRITEBACK_BYPASS_EN
  output logic [DEPTH-1:0][W-1:0]     ents_o,
`endif
  output logic [$clog2(DEPTH):0]      count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           rptr_q, rptr_d, wptr_q, wptr_d, slot_b;
  logic [CW-1:0]           count_q, count_d;

  // A lone B push takes the slot A would have used.
  assign slot_b  = wptr_q + PW'(push_a_i);
  assign wptr_d  = wptr_q + PW'(push_a_i) + PW'(push_b_i);
  assign rptr_d  = rptr_q + PW'(pop_i);
  assign count_d = count_q + CW'(push_a_i) + CW'(push_b_i) - CW'(pop_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_a_i) mem_q[wptr_q] <= din_a_i;
    if (push_b_i) mem_q[slot_b] <= din_b_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

`ifdef REG_WRITEBACK_BYPASS_EN
  always_comb begin
    ents_o = '0;
    for (int k = 0; k < DEPTH; k++) ents_o[k] = mem_q[rptr_q + PW'(k)];
  end
`endif
endmodule

// File: rtl/reg_writeback_queue.sv
// Register write-back queue: merges ALU/load results, drains one RF write per cycle, tracks in-flight dests.
// Optional REG_WRITEBACK_BYPASS_EN enables a youngest-match search of queued results.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int CNT_W  = WB_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [ADDR_W-1:0]       alu_reg,
  input  logic [DATA_W-1:0]       alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [ADDR_W-1:0]       mem_reg,
  input  logic [DATA_W-1:0]       mem_data,
  input  logic                    claim_valid,
  output logic                    claim_ready,
  input  logic [ADDR_W-1:0]       claim_reg,
  output logic [NUM_REGS-1:0]     busy,
  output logic [ADDR_W-1:0]       Write_reg,
  output logic [DATA_W-1:0]       Data,
  output logic                    RegWrite,
  output logic [$clog2(DEPTH):0]  q_count,
  input  logic [ADDR_W-1:0]       byp_reg,
  output logic                    byp_hit,
  output logic [DATA_W-1:0]       byp_data
);
  localparam int CW = cnt_w(DEPTH);
  localparam int EW = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] RZ      = ADDR_W'(REG_ZERO);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic                          push_a, push_b, pop;
  logic [EW-1:0]                 head;
  logic [ADDR_W-1:0]             head_reg;
  logic [DATA_W-1:0]             head_data;
  logic [CW-1:0]                 cnt;
  logic [CW:0]                   free;
  logic                          claim_acc;
  logic [NUM_REGS-1:0][CNT_W-1:0] sb_q, sb_d;

  // Slots freed by this cycle's pop count toward readiness; ready never looks at valid.
  assign pop       = (cnt != '0);
  assign free      = (CW+1)'(DEPTH) - {1'b0, cnt} + (CW+1)'(pop);
  assign alu_ready = (free >= (CW+1)'(1));
  assign mem_ready = (free >= (CW+1)'(2));
  assign push_a    = alu_valid && alu_ready && (alu_reg != RZ);
  assign push_b    = mem_valid && mem_ready && (mem_reg != RZ);

`ifdef REG_WRITEBACK_BYPASS_EN
  logic [DEPTH-1:0][EW-1:0] ents;
`endif

  wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_a_i (push_a),
    .din_a_i  ({alu_reg, alu_data}),
    .push_b_i (push_b),
    .din_b_i  ({mem_reg, mem_data}),
    .pop_i    (pop),
    .head_o   (head),
`ifdef REG_WRITEBACK_BYPASS_EN
    .ents_o   (ents),
`endif
    .count_o  (cnt)
  );

  assign {head_reg, head_data} = head;
  assign RegWrite  = pop;
  assign Write_reg = pop ? head_reg  : '0;
  assign Data      = pop ? head_data : '0;
  assign q_count   = cnt;

  // A saturated counter may still be claimed when its register retires this very cycle.
  assign claim_ready = (claim_reg == RZ) || (sb_q[claim_reg] != CNT_MAX) ||
                       (pop && (head_reg == claim_reg));
  assign claim_acc   = claim_valid && claim_ready && (claim_reg != RZ);

  always_comb begin
    sb_d = sb_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (claim_acc && (claim_reg == ADDR_W'(r)) && !(pop && (head_reg == ADDR_W'(r))))
        sb_d[r] = sb_q[r] + 1'b1;
      else if (pop && (head_reg == ADDR_W'(r)) && !(claim_acc && (claim_reg == ADDR_W'(r)))
               && (sb_q[r] != '0))
        sb_d[r] = sb_q[r] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) busy[r] = (sb_q[r] != '0);
  end

`ifdef REG_WRITEBACK_BYPASS_EN
  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < cnt) && (byp_reg != RZ) && (ents[k][EW-1 -: ADDR_W] == byp_reg)) begin
        byp_hit  = 1'b1;
        byp_data = ents[k][DATA_W-1:0];
      end
    end
  end
`else
  logic byp_unused;
  assign byp_unused = ^byp_reg;
  assign byp_hit    = 1'b0;
  assign byp_data   = '0;
`endif
endmodule
